// File: rtl/rbp_dump_master.sv
// rbp_dump_master: host sequencer that pulls a recorded ADC buffer out of the capture MCU over the rbp bus
// Ports: sys_clk, sys_rst_n (async, active-low); start/stop_first/abort dump control;
//        rbp_req/rbp_cmd/rbp_rst/rbp_dat/rbp_ack/rbp_data MCU 4-phase handshake bus;
//        out_data/out_valid/out_ready 16-bit FWFT stream; busy/done/error/total_words/words_read status.
module rbp_dump_master #(
   parameter logic [23:0] MAX_WORDS   = 24'hFFFFFF,
   parameter int          FIFO_DEPTH  = 16,
   parameter int          TIMEOUT_CYC = 4096,
   parameter int          RST_CYC     = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic        stop_first,
   input  logic        abort,
   output logic        rbp_req,
   output logic [3:0]  rbp_cmd,
   output logic        rbp_rst,
   output logic        rbp_dat,
   input  logic        rbp_ack,
   input  logic [15:0] rbp_data,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [23:0] total_words,
   output logic [23:0] words_read
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LIM = (AW+1)'(FIFO_DEPTH - 1);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
   localparam logic [31:0] RST_LAST = 32'(RST_CYC - 1);
   localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_REL = 3'd2, S_FIN = 3'd3, S_TRST = 3'd4;
   localparam logic [3:0] C_RST = 4'd0, C_READ = 4'd1, C_POSLO = 4'd2, C_POSHI = 4'd3, C_STOP = 4'd6;
   logic [2:0]    state;
   logic          ack_m, ack_s;
   logic [23:0]   pos;
   logic [31:0]   tmo;
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic [15:0]   mem [FIFO_DEPTH];
   logic          push, pop, room, waiting;
   assign rbp_dat   = 1'b0;
   assign busy      = state != S_IDLE;
   assign out_valid = cnt != '0;
   assign out_data  = mem[rp];
   assign push      = state == S_REQ && rbp_req && ack_s && rbp_cmd == C_READ;
   assign pop       = out_valid && out_ready;
   // a read is only requested when its word is guaranteed a free slot
   assign room      = cnt < FULL_LIM;
   // phase timer runs only while actually waiting on the MCU, not while stalled on FIFO space
   assign waiting   = (state == S_REQ && rbp_req && !ack_s) || (state == S_REL && !ack_s);
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         ack_m <= 1'b0;
         ack_s <= 1'b0;
      end else begin
         ack_m <= rbp_ack;
         ack_s <= ack_m;
      end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         wp  <= push ? wp + AW'(1) : wp;
         rp  <= pop ? rp + AW'(1) : rp;
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge sys_clk)
      if (push) mem[wp] <= rbp_data;
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state       <= S_IDLE;
         rbp_req     <= 1'b0;
         rbp_cmd     <= 4'd0;
         rbp_rst     <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         total_words <= 24'd0;
         words_read  <= 24'd0;
         pos         <= 24'd0;
         tmo         <= 32'd0;
      end else begin
         done <= 1'b0;
         tmo  <= (waiting || state == S_TRST) ? tmo + 32'd1 : 32'd0;
         if (waiting && tmo == TMO_LAST) begin
            rbp_req <= 1'b0;
            rbp_rst <= 1'b1;
            error   <= 1'b1;
            tmo     <= 32'd0;
            state   <= S_TRST;
         end else
            case (state)
               S_IDLE: if (start) begin
                  error      <= 1'b0;
                  words_read <= 24'd0;
                  rbp_cmd    <= stop_first ? C_STOP : C_POSLO;
                  state      <= S_REQ;
               end
               S_REQ: if (!rbp_req) begin
                  if (abort) state <= S_FIN;
                  else if (rbp_cmd != C_READ || room) rbp_req <= 1'b1;
               end else if (ack_s) begin
                  rbp_req <= 1'b0;
                  state   <= S_REL;
                  if (rbp_cmd == C_POSLO) pos[15:0] <= rbp_data;
                  if (rbp_cmd == C_POSHI) pos[23:16] <= rbp_data[7:0];
                  if (rbp_cmd == C_READ) words_read <= words_read + 24'd1;
               end
               S_REL: if (!ack_s) begin
                  if (abort) state <= S_FIN;
                  else if (rbp_cmd == C_STOP) begin
                     rbp_cmd <= C_POSLO;
                     state   <= S_REQ;
                  end else if (rbp_cmd == C_POSLO) begin
                     rbp_cmd <= C_POSHI;
                     state   <= S_REQ;
                  end else if (rbp_cmd == C_POSHI) begin
                     rbp_cmd     <= C_RST;
                     total_words <= pos > MAX_WORDS ? MAX_WORDS : pos;
                     state       <= S_REQ;
                  end else if (rbp_cmd == C_RST) begin
                     rbp_cmd <= C_READ;
                     state   <= total_words == 24'd0 ? S_FIN : S_REQ;
                  end else
                     state <= words_read == total_words ? S_FIN : S_REQ;
               end
               S_FIN: if (!out_valid) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
               S_TRST: if (tmo == RST_LAST) begin
                  rbp_rst <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
      end
endmodule

// File: tb/tb_rbp_dump_master.sv
// tb_rbp_dump_master: directed scoreboard bench for rbp_dump_master against a behavioural MCU model
module tb_rbp_dump_master;
   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        start = 1'b0, stop_first = 1'b0, abort = 1'b0;
   logic        rbp_req, rbp_rst, rbp_dat;
   logic [3:0]  rbp_cmd;
   logic        rbp_ack;
   logic [15:0] rbp_data;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy, done, error;
   logic [23:0] total_words, words_read;
   int          checks = 0, errors = 0;
   int          done_cnt = 0, popped = 0, rd_cnt = 0;
   bit          seen_valid = 0, served = 0;
   logic [23:0] mdl_pos = 24'd0;
   logic [15:0] mdl_addr = 16'd0;
   logic [4:0]  hang = 5'h10;
   logic [15:0] exp_q[$];
   logic [3:0]  cmd_log[$];
   logic [3:0]  exp_cmds[$];
   rbp_dump_master #(.MAX_WORDS(24'd8), .FIFO_DEPTH(4), .TIMEOUT_CYC(4096), .RST_CYC(8)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop_first(stop_first), .abort(abort),
      .rbp_req(rbp_req), .rbp_cmd(rbp_cmd), .rbp_rst(rbp_rst), .rbp_dat(rbp_dat), .rbp_ack(rbp_ack),
      .rbp_data(rbp_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .error(error), .total_words(total_words), .words_read(words_read));
   always #5 sys_clk = ~sys_clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   initial begin
      rbp_ack = 1'b0;
      rbp_data = 16'd0;
      forever begin
         @(posedge sys_clk);
         #1;
         if (!sys_rst_n || rbp_rst) rbp_ack = 1'b0;
         else if (rbp_ack) begin
            if (!rbp_req) rbp_ack = 1'b0;
         end else if (rbp_req && !served) begin
            served = 1;
            cmd_log.push_back(rbp_cmd);
            if ({1'b0, rbp_cmd} != hang) begin
               @(posedge sys_clk);
               #1;
               if (rbp_req && sys_rst_n) begin
                  case (rbp_cmd)
                     4'd2: rbp_data = mdl_pos[15:0];
                     4'd3: rbp_data = {8'hA5, mdl_pos[23:16]};
                     4'd0: begin rbp_data = 16'd0; mdl_addr = 16'd0; rd_cnt = 0; end
                     4'd1: begin
                        rbp_data = 16'hC35A ^ (mdl_addr * 16'h0123);
                        exp_q.push_back(rbp_data);
                        mdl_addr++;
                        rd_cnt++;
                     end
                     default: rbp_data = 16'h0000;
                  endcase
                  rbp_ack = 1'b1;
               end
            end
         end
         if (!rbp_req) served = 0;
      end
   end
   always @(negedge sys_clk) begin
      if (done) done_cnt++;
      if (out_valid) seen_valid = 1;
      if (out_valid && out_ready) begin
         check("stream_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("stream_word", out_data, exp_q.pop_front());
         popped++;
      end
   end
   task automatic pulse_start();
      @(posedge sys_clk);
      #1 start = 1'b1;
      @(posedge sys_clk);
      #1 start = 1'b0;
   endtask
   task automatic wait_done(input string tag, input int budget);
      bit got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge sys_clk);
         got = done;
      end
      check(tag, 32'(got), 1);
   endtask
   task automatic check_cmds(input string tag, input logic [3:0] e[$]);
      check({tag, "_len"}, cmd_log.size(), e.size());
      foreach (e[i]) if (i < cmd_log.size()) check($sformatf("%s_%0d", tag, i), cmd_log[i], e[i]);
   endtask
   function automatic int n_cmd(input logic [3:0] c);
      int n = 0;
      foreach (cmd_log[i]) if (cmd_log[i] == c) n++;
      return n;
   endfunction
   task automatic new_test(input logic [23:0] p, input logic sf, input logic rdy);
      mdl_pos = p;
      stop_first = sf;
      out_ready = rdy;
      cmd_log.delete();
      done_cnt = 0;
      popped = 0;
      seen_valid = 0;
   endtask
   initial begin
      int n;
      repeat (3) @(negedge sys_clk);
      check("rst_req", rbp_req, 0);
      check("rst_cmd", rbp_cmd, 0);
      check("rst_rst", rbp_rst, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_total", total_words, 0);
      check("rst_words", words_read, 0);
      check("rst_valid", out_valid, 0);
      check("rst_dat", rbp_dat, 0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      new_test(24'h000005, 1'b1, 1'b1);
      pulse_start();
      wait_done("t1_done", 2000);
      repeat (3) @(negedge sys_clk);
      exp_cmds = '{4'd6, 4'd2, 4'd3, 4'd0};
      repeat (5) exp_cmds.push_back(4'd1);
      check_cmds("t1_cmd", exp_cmds);
      check("t1_total", total_words, 5);
      check("t1_words", words_read, 5);
      check("t1_popped", popped, 5);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_drained", exp_q.size(), 0);
      check("t1_busy", busy, 0);
      new_test(24'h000000, 1'b0, 1'b1);
      pulse_start();
      wait_done("t2_done", 2000);
      repeat (3) @(negedge sys_clk);
      exp_cmds = '{4'd2, 4'd3, 4'd0};
      check_cmds("t2_cmd", exp_cmds);
      check("t2_valid_seen", 32'(seen_valid), 0);
      check("t2_total", total_words, 0);
      check("t2_done_cnt", done_cnt, 1);
      new_test(24'h010000, 1'b0, 1'b0);
      pulse_start();
      repeat (150) @(negedge sys_clk);
      check("t3_stall_reads", n_cmd(4'd1), 3);
      check("t3_stall_req", rbp_req, 0);
      check("t3_stall_busy", busy, 1);
      check("t3_stall_words", words_read, 3);
      check("t3_stall_valid", out_valid, 1);
      check("t3_total", total_words, 8);
      out_ready = 1'b1;
      wait_done("t3_done", 2000);
      repeat (3) @(negedge sys_clk);
      check("t3_reads", n_cmd(4'd1), 8);
      check("t3_words", words_read, 8);
      check("t3_popped", popped, 8);
      check("t3_drained", exp_q.size(), 0);
      new_test(24'h000006, 1'b0, 1'b1);
      pulse_start();
      n = 0;
      while (!(rd_cnt == 3 && rbp_ack) && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      check("t4_third_ack", 32'(rd_cnt == 3 && rbp_ack), 1);
      abort = 1'b1;
      wait_done("t4_done", 2000);
      abort = 1'b0;
      repeat (20) @(negedge sys_clk);
      check("t4_reads", n_cmd(4'd1), 3);
      check("t4_words", words_read, 3);
      check("t4_popped", popped, 3);
      check("t4_drained", exp_q.size(), 0);
      check("t4_done_cnt", done_cnt, 1);
      new_test(24'h000004, 1'b0, 1'b1);
      hang = 5'd2;
      pulse_start();
      for (int i = 0; i < 100 && !rbp_req; i++) @(negedge sys_clk);
      n = 0;
      while (rbp_req && n < 10000) begin
         n++;
         @(negedge sys_clk);
      end
      check("to_req_cycles", n, 4096);
      check("to_rst_on", rbp_rst, 1);
      n = 0;
      while (rbp_rst && n < 100) begin
         n++;
         @(negedge sys_clk);
      end
      check("to_rst_cycles", n, 8);
      check("to_done", done, 1);
      check("to_error", error, 1);
      check("to_busy", busy, 0);
      hang = 5'h10;
      repeat (3) @(negedge sys_clk);
      check("to_done_cnt", done_cnt, 1);
      check("to_error_sticky", error, 1);
      new_test(24'h000002, 1'b0, 1'b1);
      pulse_start();
      check("to_error_clr", error, 0);
      wait_done("to_rerun_done", 2000);
      check("to_rerun_words", words_read, 2);
      new_test(24'h000008, 1'b0, 1'b0);
      pulse_start();
      n = 0;
      while (rd_cnt < 2 && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      check("rs_mid_read", 32'(rd_cnt >= 2), 1);
      #2 sys_rst_n = 1'b0;
      #1;
      check("rs_req", rbp_req, 0);
      check("rs_busy", busy, 0);
      check("rs_valid", out_valid, 0);
      check("rs_words", words_read, 0);
      check("rs_total", total_words, 0);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      exp_q.delete();
      repeat (3) @(negedge sys_clk);
      new_test(24'h000006, 1'b1, 1'b1);
      pulse_start();
      wait_done("rs_clean_done", 2000);
      repeat (3) @(negedge sys_clk);
      exp_cmds = '{4'd6, 4'd2, 4'd3, 4'd0};
      repeat (6) exp_cmds.push_back(4'd1);
      check_cmds("rs_cmd", exp_cmds);
      check("rs_clean_total", total_words, 6);
      check("rs_clean_popped", popped, 6);
      check("rs_clean_drained", exp_q.size(), 0);
      check("rs_clean_error", error, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rbp_dump_master.md
Name: rbp_dump_master

Overview:
- Host-side sequencer that drives the 4-phase rbp request/ack bus of the capture MCU and pulls out a recorded ADC buffer.
- Sequence: optionally stop recording, read the 24-bit write position, reset the read address, then issue one read per stored word.
- Read words go through a small FIFO and leave as a 16-bit valid/ready stream for the downstream packetiser/DMA.

Parameters:
- MAX_WORDS, 24'hFFFFFF: cap on words read per dump.
- FIFO_DEPTH, 16: output FIFO depth in 16-bit words; power of 2, minimum 4.
- TIMEOUT_CYC, 4096: maximum sys_clk cycles spent waiting in any single handshake phase.
- RST_CYC, 8: number of cycles rbp_rst is held high after a timeout.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a dump; ignored while busy
- stop_first  in  1  sampled at start; 1 = issue cmd 6 (stop record) first
- abort  in  1  level; ends the dump at the next handshake boundary
- rbp_req  out  1  request to the MCU
- rbp_cmd  out  4  command code
- rbp_rst  out  1  handshake reset to the MCU
- rbp_dat  out  1  tied 0
- rbp_ack  in  1  acknowledge; asynchronous, 2-flop synchronised to ack_s
- rbp_data  in  16  MCU data; valid while ack_s is high
- out_data  out  16  stream data, FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accept
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on completion or abort
- error  out  1  sticky timeout flag; cleared by the next start
- total_words  out  24  clamped word count latched from the position reads
- words_read  out  24  reads completed in the current dump

Behaviour:
- Reset values: rbp_req, rbp_cmd, rbp_rst, busy, done, error, total_words, words_read all 0; out_valid 0; FIFO empty; state IDLE.
- Command sequence: [STOP cmd 6] -> POS_LO cmd 2 -> POS_HI cmd 3 -> RST_ADDR cmd 0 -> READ cmd 1 repeated -> FIN.
- Each command runs as a two-phase handshake:
  - REQ: drive rbp_cmd, rbp_req=1, wait for ack_s=1.
  - REL: rbp_req=0, wait for ack_s=0.
  - rbp_cmd is stable from the cycle before rbp_req rises until REL completes.
- rbp_data is captured on the first cycle ack_s=1 in REQ:
  - POS_LO: position[15:0].
  - POS_HI: position[23:16] = rbp_data[7:0].
  - READ: FIFO write.
- Entering RST_ADDR: total_words <= min(position, MAX_WORDS).
- After RST_ADDR: if total_words==0 go straight to FIN with no reads.
- READ gating: rbp_req rises only when FIFO occupancy + 1 < FIFO_DEPTH. This guarantees a slot for the incoming word; it is never dropped.
- READ bookkeeping: words_read increments on the capture cycle. When words_read reaches total_words after REL, go to FIN.
- FIN: wait for the FIFO to be empty, pulse done, then return to IDLE.
- abort:
  - Sampled only in REQ before rbp_req rises, or at REL completion.
  - Mid-handshake, the current handshake completes first.
  - Then go to FIN; the FIFO still drains and done pulses.
- Timeout: a per-phase counter resets on every phase entry. Reaching TIMEOUT_CYC in REQ or REL:
  - rbp_req=0, rbp_rst=1 for RST_CYC cycles, error=1.
  - Then IDLE, with done pulsed once.
  - FIFO contents are kept and remain drainable in IDLE.
- FIFO:
  - Registered, first-word-fall-through.
  - Simultaneous push and pop on a full or empty FIFO is legal; occupancy stays consistent.
  - Pointers wrap modulo FIFO_DEPTH.
- start while busy: ignored. start in IDLE: clears error and words_read.
- Asynchronous reset mid-dump: every output returns to its reset value immediately; the MCU side recovers on its own when req drops.

Test Plan:
- stop_first=1, MCU model returns pos 0x000005 -> cmd sequence 6,2,3,0,1×5 on the bus; stream carries the 5 model words in order; total_words=5; one done pulse.
- Pos 0x000000 -> no cmd 1 issued; done pulses; out_valid never asserts.
- MAX_WORDS=8, pos 0x010000, out_ready=0 -> exactly FIFO_DEPTH-1 reads, then rbp_req stays low. Raise out_ready -> remaining reads resume; 8 words total.
- Model never acks cmd 2 -> after TIMEOUT_CYC cycles rbp_req=0, rbp_rst high for 8 cycles, error=1, done pulse. A new start clears error.
- abort asserted while the 3rd read's ack is high -> 3rd word delivered, no 4th request, done after the FIFO drains, words_read=3.
- sys_rst_n pulsed low in the middle of READ -> rbp_req=0, FIFO empty, busy=0 immediately. A subsequent start runs a clean full dump.
